// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// alu_muldiv_pkg : op/state encodings and signed-min constants for the
//                  iterative RV32M/RV64M multiply/divide unit
// Revision       : 1.0
// ============================================================================
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [63:0] C_SMIN_XLEN32 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] C_SMIN_XLEN64 = 64'h8000_0000_0000_0000;

  // Most negative signed value for the given width, right-aligned in 64 bits.
  function automatic logic [63:0] smin_pattern(input int xlen);
    return (xlen == 64) ? C_SMIN_XLEN64 : C_SMIN_XLEN32;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
// muldiv_datapath : shared 2*XLEN shift register, add/sub unit and sign fix
//                   for shift-add multiply and restoring divide
// Revision        : 1.0
// ============================================================================
module muldiv_datapath
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            fast_hit,
  output logic [XLEN-1:0] fast_result,
  output logic [XLEN-1:0] final_result
);

  localparam logic [63:0]      c_smin_full = smin_pattern(XLEN);
  localparam logic [XLEN-1:0]  c_smin      = c_smin_full[XLEN-1:0];

  op_e               w_op;
  logic              w_in_div;
  logic              w_sign1;
  logic              w_sign2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_dz;
  logic              w_ovf;

  op_e               r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic              r_neg_a;
  logic              r_neg_b;

  logic              w_div;
  logic [XLEN:0]     w_add_a;
  logic [XLEN+1:0]   w_sum;
  logic              w_ge;
  logic [XLEN:0]     w_mul_hi;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_op     = op_e'(op);
  assign w_in_div = op[2];
  assign w_sign1  = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                    (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_sign2  = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                    (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_neg1   = w_sign1 & rs1[XLEN-1];
  assign w_neg2   = w_sign2 & rs2[XLEN-1];
  assign w_mag1   = w_neg1 ? (~rs1 + 1'b1) : rs1;
  assign w_mag2   = w_neg2 ? (~rs2 + 1'b1) : rs2;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_dz        = w_in_div && (rs2 == '0);
  assign w_ovf       = ((w_op == OP_DIV) || (w_op == OP_REM)) && (rs1 == c_smin) && (&rs2);
  assign fast_hit    = w_dz || w_ovf;
  assign fast_result = w_dz ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);

  // One adder serves both: hi+multiplicand, or shifted remainder - divisor.
  assign w_div    = r_op[2];
  assign w_add_a  = w_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
  assign w_sum    = {1'b0, w_add_a}
                  + (w_div ? ~{2'b00, r_opb} : {2'b00, r_opb})
                  + {{(XLEN+1){1'b0}}, w_div};
  assign w_ge     = ~w_sum[XLEN+1];
  assign w_mul_hi = r_acc[0] ? w_sum[XLEN:0] : {1'b0, r_acc[2*XLEN-1:XLEN]};

  assign w_acc_next = w_div
                    ? {(w_ge ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0]), r_acc[XLEN-2:0], w_ge}
                    : {w_mul_hi, r_acc[XLEN-1:1]};

  assign w_prod = r_neg_a ? (~w_acc_next + 1'b1) : w_acc_next;
  assign w_quo  = w_acc_next[XLEN-1:0];
  assign w_rem  = w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    final_result = '0;
    case (r_op)
      OP_MUL:                         final_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   final_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                final_result = r_neg_a ? (~w_quo + 1'b1) : w_quo;
      OP_REM, OP_REMU:                final_result = r_neg_b ? (~w_rem + 1'b1) : w_rem;
      default:                        final_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_MUL;
      r_acc   <= '0;
      r_opb   <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
    end else if (load) begin
      r_op    <= w_op;
      r_acc   <= w_in_div ? {{XLEN{1'b0}}, w_mag1} : {{XLEN{1'b0}}, w_mag2};
      r_opb   <= w_in_div ? w_mag2 : w_mag1;
      r_neg_a <= w_neg1 ^ w_neg2;
      r_neg_b <= w_neg1;
    end else if (step) begin
      r_acc   <= w_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// alu_muldiv_seq : iterative RV32M/RV64M multiply/divide unit with
//                  valid/ready handshakes; FSM, counter and result register
// Revision       : 1.0
// ============================================================================
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int c_cw = $clog2(XLEN) + 1;

  state_e          r_state;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_next;
  logic            w_accept;
  logic            w_step;
  logic            w_fast_hit;
  logic [XLEN-1:0] w_fast_result;
  logic [XLEN-1:0] w_final;

  assign w_accept   = in_valid && (r_state == ST_IDLE) && !flush;
  assign w_step     = (r_state == ST_CALC) && !flush;
  assign w_cnt_next = r_cnt - c_cw'(1);

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (w_accept),
    .step         (w_step),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .fast_hit     (w_fast_hit),
    .fast_result  (w_fast_result),
    .final_result (w_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      // Abort leaves the last presented result in place.
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (w_fast_hit) begin
              r_state   <= ST_DONE;
              out_valid <= 1'b1;
              result    <= w_fast_result;
            end else begin
              r_state <= ST_CALC;
              r_cnt   <= c_cw'(XLEN);
            end
          end
        end
        ST_CALC: begin
          r_cnt <= w_cnt_next;
          if (w_cnt_next == '0) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            result    <= w_final;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_muldiv_seq : self-checking bench for alu_muldiv_seq (XLEN=32)
// Revision          : 1.0
// ============================================================================
module tb_alu_muldiv_seq;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the RISC-V M-extension arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op from IDLE with out_ready high; lat = first negedge index
  // (1 = just after the accept edge) at which out_valid is seen, -1 on timeout.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output bit busy_ok);
    lat = -1; res = '0; busy_ok = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= XLEN + 8; k++) begin
      if (k > 1) @(negedge clk);
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) begin
        lat = k; res = result;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    int lat; logic [31:0] res; bit busy;
    v = '{
      '{3'd0, 32'hFFFF_FFFB, 32'h4,         32'hFFFF_FFEC, 33},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
      '{3'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33},
      '{3'd4, 32'hFFFF_FFFB, 32'h4,         32'hFFFF_FFFF, 33},
      '{3'd6, 32'hFFFF_FFFB, 32'h4,         32'hFFFF_FFFF, 33},
      '{3'd5, 32'hFFFF_FFFB, 32'h4,         32'h3FFF_FFFE, 33},
      '{3'd5, 32'd10,        32'h0,         32'hFFFF_FFFF, 1},
      '{3'd7, 32'd10,        32'h0,         32'd10,        1},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1},
      '{3'd4, 32'd7,         32'h0,         32'hFFFF_FFFF, 1}
    };
    for (int i = 0; i < 12; i++) begin
      issue(v[i].o, v[i].a, v[i].b, lat, res, busy);
      checks++;
      if (res !== v[i].exp) begin
        errors++; $display("FAIL directed_result[%0d] op=%0d got=%h exp=%h", i, v[i].o, res, v[i].exp);
      end
      checks++;
      if (lat != v[i].lat) begin
        errors++; $display("FAIL directed_latency[%0d] op=%0d got=%0d exp=%0d", i, v[i].o, lat, v[i].lat);
      end
      checks++;
      if (!busy) begin
        errors++; $display("FAIL directed_in_ready_busy[%0d] got=1 exp=0 while busy", i);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; bit busy;
    logic [2:0] o; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      issue(o, a, b, lat, res, busy);
      checks++;
      if (res !== model(o, a, b)) begin
        errors++; $display("FAIL random_result op=%0d a=%h b=%h got=%h exp=%h", o, a, b, res, model(o, a, b));
      end
      checks++;
      if (lat != model_lat(o, a, b)) begin
        errors++; $display("FAIL random_latency op=%0d a=%h b=%h got=%0d exp=%0d", o, a, b, lat, model_lat(o, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1, exp2;
    bit got;
    int lat;
    exp1 = model(3'd4, 32'd1000, 32'hFFFF_FFF9);
    exp2 = model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'hFFFF_FFF9; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL bp_out_valid_timeout got=0 exp=1"); end
    // Second request held on the bus while the first result is stalled.
    in_valid = 1'b1; op = 3'd3; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, exp1}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b res=%h exp v=1 r=0 res=%h", k, out_valid, in_ready, result, exp1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept in_ready got=%b exp=0", in_ready); end
    lat = -1;
    for (int k = 1; k <= XLEN + 8; k++) begin
      if (k > 1) @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    checks++;
    if (lat != XLEN + 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, XLEN + 1); end
    checks++;
    if (result !== exp2) begin errors++; $display("FAIL b2b_result got=%h exp=%h", result, exp2); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat; logic [31:0] res; bit busy; bit seen;
    issue(3'd5, 32'd100, 32'd7, lat, res, busy);
    checks++;
    if (res !== 32'd14) begin errors++; $display("FAIL abort_setup got=%h exp=%h", res, 32'd14); end
    // flush ten cycles into a DIV
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; rs1 = 32'h1234_5678; rs2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'd14}) begin
      errors++; $display("FAIL flush_state got v=%b r=%b res=%h exp v=0 r=1 res=%h", out_valid, in_ready, result, 32'd14);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_no_output got=1 exp=0"); end
    // reset pulse twenty cycles into a MUL
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; rs1 = 32'd12345; rs2 = 32'd678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL midreset_state got v=%b r=%b res=%h exp v=0 r=1 res=0", out_valid, in_ready, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_output got=1 exp=0"); end
    // flush together with a request in IDLE drops it
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'd5; rs1 = 32'd9; rs2 = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (10) begin if (out_valid || !in_ready) seen = 1'b1; @(negedge clk); end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_drop got=accepted exp=dropped"); end
    issue(3'd0, 32'd12345, 32'd678, lat, res, busy);
    checks++;
    if (res !== model(3'd0, 32'd12345, 32'd678)) begin
      errors++; $display("FAIL post_abort_result got=%h exp=%h", res, model(3'd0, 32'd12345, 32'd678));
    end
    checks++;
    if (lat != XLEN + 1) begin errors++; $display("FAIL post_abort_latency got=%0d exp=%0d", lat, XLEN + 1); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative multi-cycle multiply/divide unit implementing the RV32M/RV64M operation set at a parametrised data width, with valid/ready handshakes on input and output. It sits beside the single-cycle integer ALU in the execute stage. MUL/DIV-class operations are steered here instead of through a combinational multiplier/divider. The block computes full 2*XLEN products for the high-half variants and applies the RISC-V divide-by-zero and signed-overflow rules.

Parameters:
XLEN, 32, operand/result width in bits; legal values are 32 and 64.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; discards any in-flight or held operation
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept a request
op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  in  XLEN  operand 1 (multiplicand / dividend)
rs2  in  XLEN  operand 2 (multiplier / divisor)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, result=0. All internal registers and the counter are cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch op and operands.
    - Fast path: divisor==0 or signed overflow goes to DONE.
    - All other operations go to CALC.
  - CALC: in_ready=0. Performs one iteration per cycle for XLEN cycles, then goes to DONE.
  - DONE: out_valid=1, in_ready=0. When out_ready is high, goes to IDLE.
- Latency, counted from the accept edge = cycle 0:
  - Normal: out_valid rises at cycle XLEN+1.
  - Fast path: out_valid rises at cycle 1.
- No new request is accepted in the cycle out_valid drops.
- Handshake: result and out_valid hold stable until out_ready is sampled high. in_valid is ignored outside IDLE.
- Multiply:
  - Operands are sign-extended to XLEN+1 bits: rs1 for MUL/MULH/MULHSU, rs2 for MUL/MULH; zero-extended otherwise.
  - Magnitudes are taken, then XLEN cycles of shift-add build an unsigned 2*XLEN product.
  - The product is negated at completion if the operand signs differed.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Quotient is negated if signs differed (signed ops only).
  - Remainder takes the sign of the dividend.
  - Results truncate toward zero.
- Divide by zero (rs2==0): quotient = all ones; remainder = rs1. Applies to both signed and unsigned ops.
- Signed overflow (DIV/REM with rs1 = 1 followed by XLEN-1 zeros and rs2 = all ones): quotient = rs1; remainder = 0.
- Iteration counter width is clog2(XLEN)+1. It counts down from XLEN; reaching 0 ends CALC.
- flush:
  - In any state, the next state is IDLE and out_valid=0 on the next edge. The result register is unchanged.
  - flush together with in_valid in IDLE: the request is dropped.
- Reset asserted mid-CALC or mid-DONE: immediate return to the reset values; no partial result is presented.

Decomposition:
- Package alu_muldiv_pkg holds:
  - the op enum (funct3 codes);
  - the state enum (IDLE/CALC/DONE);
  - helper constants for the signed-min pattern per XLEN.
- Sub-module muldiv_datapath holds the shared 2*XLEN accumulator/shift register, the add/subtract unit and the sign-fix logic. The top level keeps the FSM, counter and handshake.

Test Plan:
- XLEN=32, MUL rs1=0xFFFFFFFB, rs2=4, out_ready=1 -> result 0xFFFFFFEC; out_valid at cycle 33; in_ready low cycles 1..33.
- MULH rs1=rs2=0x80000000 -> 0x40000000. MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFFB (-5), rs2=4 -> 0xFFFFFFFF. REM with the same operands -> 0xFFFFFFFF. DIVU with the same operands -> 0x3FFFFFFE.
- DIVU rs1=10, rs2=0 -> 0xFFFFFFFF. REMU -> 10. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. All on the fast path, out_valid at cycle 1.
- Backpressure: out_ready low for 5 cycles after out_valid -> result stable, in_valid ignored. Raise out_ready -> IDLE next cycle, then back-to-back second op accepted.
- flush at cycle 10 of a DIV, and rst_n pulsed low at cycle 20 of a MUL -> no out_valid for the aborted op. The next op returns the correct result.
